// File: rtl/uart_controller.sv
// uart_controller: full-duplex 8N1 UART (LSB first) with an optional internal
// loopback that routes the transmit line into the receiver.
// The transmitter sends a byte whenever it is idle and i_Tx_Ready is high.
// The receiver rejects start glitches and decides every bit by a 3-sample
// majority vote around the bit centre.
module uart_controller #(
   parameter int CLOCK_RATE    = 25000000,
   parameter int BAUD_RATE     = 115200,
   parameter int RX_OVERSAMPLE = 16,
   parameter int LOOPBACK      = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_Tx_Ready,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Data,
   output logic       o_Tx_Done,
   input  logic       i_Rx_Data,
   output logic       o_Rx_Done,
   output logic [7:0] o_Rx_Byte
);

   localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
   localparam int VOTE_OFS     = CLKS_PER_BIT / RX_OVERSAMPLE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + VOTE_OFS + 1);

   // Counter compare points. The RX bit counter is referenced to the previous
   // mid-bit, so the next bit's three votes fall at CLKS_PER_BIT - VOTE_OFS,
   // CLKS_PER_BIT and CLKS_PER_BIT + VOTE_OFS cycles after it.
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] VOTE_PRE   = CNT_W'(CLKS_PER_BIT - VOTE_OFS - 1);
   localparam logic [CNT_W-1:0] VOTE_MID   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] VOTE_POST  = CNT_W'(CLKS_PER_BIT + VOTE_OFS - 1);
   localparam logic [CNT_W-1:0] VOTE_REARM = CNT_W'(VOTE_OFS);

   localparam logic [2:0] TX_IDLE    = 3'd0;
   localparam logic [2:0] TX_START   = 3'd1;
   localparam logic [2:0] TX_DATA    = 3'd2;
   localparam logic [2:0] TX_STOP    = 3'd3;
   localparam logic [2:0] TX_CLEANUP = 3'd4;

   localparam logic [2:0] RX_IDLE    = 3'd0;
   localparam logic [2:0] RX_START   = 3'd1;
   localparam logic [2:0] RX_DATA    = 3'd2;
   localparam logic [2:0] RX_STOP    = 3'd3;
   localparam logic [2:0] RX_FERR    = 3'd4;

   // Two-out-of-three vote used for every received bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [2:0]       tx_state_r;
   logic [CNT_W-1:0] tx_cnt_r;
   logic [2:0]       tx_idx_r;
   logic [7:0]       tx_shift_r;
   logic             tx_data_r;
   logic             tx_active_r;
   logic             tx_done_r;

   logic             rx_src_s;
   logic             rx_sync1_r;
   logic             rx_line_r;
   logic [2:0]       rx_state_r;
   logic [CNT_W-1:0] rx_cnt_r;
   logic [2:0]       rx_idx_r;
   logic [7:0]       rx_shift_r;
   logic [1:0]       rx_vote_r;
   logic             rx_vote_s;
   logic [7:0]       rx_byte_r;
   logic             rx_done_r;

   assign o_Tx_Data   = tx_data_r;
   assign o_Tx_Active = tx_active_r;
   assign o_Tx_Done   = tx_done_r;
   assign o_Rx_Done   = rx_done_r;
   assign o_Rx_Byte   = rx_byte_r;

   // TX sequencer: start, eight data bits, stop, then a one-cycle cleanup.
   // Cleanup also samples i_Tx_Ready so back-to-back frames repeat every
   // 10*CLKS_PER_BIT+1 cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_r  <= TX_IDLE;
         tx_cnt_r    <= '0;
         tx_idx_r    <= 3'd0;
         tx_shift_r  <= 8'h00;
         tx_data_r   <= 1'b1;
         tx_active_r <= 1'b0;
         tx_done_r   <= 1'b0;
      end else begin
         tx_done_r <= 1'b0;
         case (tx_state_r)
            TX_IDLE, TX_CLEANUP: begin
               tx_cnt_r <= '0;
               tx_idx_r <= 3'd0;
               if (i_Tx_Ready) begin
                  tx_shift_r  <= i_Tx_Byte;
                  tx_data_r   <= 1'b0;
                  tx_active_r <= 1'b1;
                  tx_state_r  <= TX_START;
               end else begin
                  tx_data_r   <= 1'b1;
                  tx_active_r <= 1'b0;
                  tx_state_r  <= TX_IDLE;
               end
            end
            TX_START: begin
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r   <= '0;
                  tx_data_r  <= tx_shift_r[0];
                  tx_state_r <= TX_DATA;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            TX_DATA: begin
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r <= '0;
                  if (tx_idx_r == 3'd7) begin
                     tx_data_r  <= 1'b1;
                     tx_state_r <= TX_STOP;
                  end else begin
                     tx_data_r  <= tx_shift_r[1];
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                     tx_idx_r   <= tx_idx_r + 3'd1;
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            TX_STOP: begin
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r    <= '0;
                  tx_active_r <= 1'b0;
                  tx_done_r   <= 1'b1;
                  tx_state_r  <= TX_CLEANUP;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            default: begin
               tx_cnt_r    <= '0;
               tx_data_r   <= 1'b1;
               tx_active_r <= 1'b0;
               tx_state_r  <= TX_IDLE;
            end
         endcase
      end
   end

   assign rx_src_s = (LOOPBACK != 0) ? tx_data_r : i_Rx_Data;

   // Two-flop synchroniser for the asynchronous receive line (idles high).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync1_r <= 1'b1;
         rx_line_r  <= 1'b1;
      end else begin
         rx_sync1_r <= rx_src_s;
         rx_line_r  <= rx_sync1_r;
      end
   end

   // Majority of the two stored early samples and the live late sample.
   always_comb begin
      rx_vote_s = 1'b0;
      rx_vote_s = maj3(rx_vote_r[0], rx_vote_r[1], rx_line_r);
   end

   // RX sequencer: glitch-checked start, then eight voted data bits and a
   // voted stop bit. A bad stop bit discards the byte and waits for idle line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= '0;
         rx_idx_r   <= 3'd0;
         rx_shift_r <= 8'h00;
         rx_vote_r  <= 2'b00;
         rx_byte_r  <= 8'h00;
         rx_done_r  <= 1'b0;
      end else begin
         rx_done_r <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               rx_cnt_r <= '0;
               rx_idx_r <= 3'd0;
               if (!rx_line_r) begin
                  rx_state_r <= RX_START;
               end else begin
                  rx_state_r <= RX_IDLE;
               end
            end
            RX_START: begin
               if (rx_cnt_r == HALF_LAST) begin
                  rx_cnt_r <= '0;
                  if (!rx_line_r) begin
                     rx_state_r <= RX_DATA;
                  end else begin
                     rx_state_r <= RX_IDLE;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            RX_DATA, RX_STOP: begin
               if (rx_cnt_r == VOTE_POST) begin
                  rx_cnt_r <= VOTE_REARM;
                  if (rx_state_r == RX_DATA) begin
                     rx_shift_r <= {rx_vote_s, rx_shift_r[7:1]};
                     rx_idx_r   <= rx_idx_r + 3'd1;
                     if (rx_idx_r == 3'd7) begin
                        rx_state_r <= RX_STOP;
                     end else begin
                        rx_state_r <= RX_DATA;
                     end
                  end else if (rx_vote_s) begin
                     rx_byte_r  <= rx_shift_r;
                     rx_done_r  <= 1'b1;
                     rx_state_r <= RX_IDLE;
                  end else begin
                     rx_state_r <= RX_FERR;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
                  if (rx_cnt_r == VOTE_PRE) begin
                     rx_vote_r[0] <= rx_line_r;
                  end else if (rx_cnt_r == VOTE_MID) begin
                     rx_vote_r[1] <= rx_line_r;
                  end else begin
                     rx_vote_r <= rx_vote_r;
                  end
               end
            end
            RX_FERR: begin
               rx_cnt_r <= '0;
               if (rx_line_r) begin
                  rx_state_r <= RX_IDLE;
               end else begin
                  rx_state_r <= RX_FERR;
               end
            end
            default: begin
               rx_cnt_r   <= '0;
               rx_state_r <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_controller.sv
// Directed bench for uart_controller at default timing (217 clocks per bit).
// dut_lb runs in loopback mode; dut_ext receives from a bench-driven line.
module tb_uart_controller;

   localparam int CPB = 217;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       lb_rx_in = 1'b0;
   logic       lb_tx_active, lb_tx_data, lb_tx_done, lb_rx_done;
   logic [7:0] lb_rx_byte;

   logic       ext_tx_ready = 1'b0;
   logic [7:0] ext_tx_byte = 8'h00;
   logic       ext_rx = 1'b1;
   logic       ext_tx_active, ext_tx_data, ext_tx_done, ext_rx_done;
   logic [7:0] ext_rx_byte;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int ext_done_cnt = 0;

   logic [7:0] stream [8] = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88};

   uart_controller #(.LOOPBACK(1)) dut_lb (
      .clk(clk), .reset_n(reset_n),
      .i_Tx_Ready(tx_ready), .i_Tx_Byte(tx_byte),
      .o_Tx_Active(lb_tx_active), .o_Tx_Data(lb_tx_data), .o_Tx_Done(lb_tx_done),
      .i_Rx_Data(lb_rx_in), .o_Rx_Done(lb_rx_done), .o_Rx_Byte(lb_rx_byte)
   );

   uart_controller #(.LOOPBACK(0)) dut_ext (
      .clk(clk), .reset_n(reset_n),
      .i_Tx_Ready(ext_tx_ready), .i_Tx_Byte(ext_tx_byte),
      .o_Tx_Active(ext_tx_active), .o_Tx_Data(ext_tx_data), .o_Tx_Done(ext_tx_done),
      .i_Rx_Data(ext_rx), .o_Rx_Done(ext_rx_done), .o_Rx_Byte(ext_rx_byte)
   );

   // 25 MHz clock.
   always #20 clk = ~clk;

   // Free-running cycle count for measuring frame spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Count receive pulses of the externally driven receiver.
   always @(negedge clk) if (ext_rx_done === 1'b1) ext_done_cnt <= ext_done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected TX line k cycles after the frame-start edge.
   function automatic logic line_model(input logic [7:0] b, input int k);
      if (k < CPB) return 1'b0;
      else if (k < 9 * CPB) return b[(k - CPB) / CPB];
      else return 1'b1;
   endfunction

   // Caller has tx_ready=1 with tx_byte=b; the next rising edge starts the frame.
   task automatic run_tx_frame(input logic [7:0] b, input string tag);
      int wave_err = 0;
      int act_cnt = 0;
      int done_cnt = 0;
      int done_at = -1;
      int rx_cnt = 0;
      for (int k = 0; k < 2200; k++) begin
         @(negedge clk);
         if (k == 0) tx_ready = 1'b0;
         if (lb_tx_data !== line_model(b, k)) wave_err++;
         if (lb_tx_active === 1'b1) act_cnt++;
         if (lb_tx_done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (lb_rx_done === 1'b1) rx_cnt++;
      end
      check({tag, "_wave_err"}, wave_err, 0);
      check({tag, "_active_cycles"}, act_cnt, 2170);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_done_cycle"}, done_at, 2170);
      check({tag, "_rx_pulses"}, rx_cnt, 1);
      check({tag, "_rx_byte"}, {24'd0, lb_rx_byte}, {24'd0, b});
   endtask

   task automatic wait_lb_rx(output int at);
      at = -1;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (lb_rx_done === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic send_ext(input logic [7:0] b, input logic stop);
      ext_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ext_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      ext_rx = stop;
      repeat (CPB) @(negedge clk);
      ext_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   initial begin
      int at;
      int prev;
      prev = 0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tx_data", lb_tx_data, 1'b1);
      check("rst_tx_active", lb_tx_active, 1'b0);
      check("rst_tx_done", lb_tx_done, 1'b0);
      check("rst_rx_done", lb_rx_done, 1'b0);
      check("rst_rx_byte", lb_rx_byte, 8'h00);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single 0x55 frame: exact waveform, active window, done pulse
      tx_byte = 8'h55;
      tx_ready = 1'b1;
      run_tx_frame(8'h55, "tx55");

      // Loopback stream, byte updated on each receive pulse
      tx_byte = stream[0];
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_lb_rx(at);
         check($sformatf("stream%0d_timeout", i), (at >= 0), 1'b1);
         check($sformatf("stream%0d_byte", i), {24'd0, lb_rx_byte}, {24'd0, stream[i]});
         if (i > 0) check($sformatf("stream%0d_period", i), at - prev, 2171);
         prev = at;
         if (i < 7) tx_byte = stream[i + 1];
         else tx_ready = 1'b0;
      end
      repeat (200) @(negedge clk);
      check("stream_end_active", lb_tx_active, 1'b0);
      check("stream_end_line", lb_tx_data, 1'b1);

      // External receive: two good frames
      send_ext(8'hA5, 1'b1);
      check("ext_a5_pulses", ext_done_cnt, 1);
      check("ext_a5_byte", ext_rx_byte, 8'hA5);
      send_ext(8'h3C, 1'b1);
      check("ext_3c_pulses", ext_done_cnt, 2);
      check("ext_3c_byte", ext_rx_byte, 8'h3C);

      // Framing error keeps the previous byte, then a good frame
      send_ext(8'h5A, 1'b0);
      check("ferr_pulses", ext_done_cnt, 2);
      check("ferr_byte_held", ext_rx_byte, 8'h3C);
      send_ext(8'h11, 1'b1);
      check("after_ferr_pulses", ext_done_cnt, 3);
      check("after_ferr_byte", ext_rx_byte, 8'h11);

      // 50-cycle start glitch is ignored and the receiver stays usable
      ext_rx = 1'b0;
      repeat (50) @(negedge clk);
      ext_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_pulses", ext_done_cnt, 3);
      check("glitch_byte", ext_rx_byte, 8'h11);
      send_ext(8'h7E, 1'b1);
      check("after_glitch_pulses", ext_done_cnt, 4);
      check("after_glitch_byte", ext_rx_byte, 8'h7E);

      // Idle transmitter of the external instance is undisturbed
      check("ext_tx_line", ext_tx_data, 1'b1);
      check("ext_tx_active", ext_tx_active, 1'b0);
      check("ext_tx_done", ext_tx_done, 1'b0);

      // Reset during the data phase, then a fresh full frame
      tx_byte = 8'hC3;
      tx_ready = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("pre_rst_active", lb_tx_active, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_line", lb_tx_data, 1'b1);
      check("mid_rst_active", lb_tx_active, 1'b0);
      check("mid_rst_rx_byte", lb_rx_byte, 8'h00);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      run_tx_frame(8'hC3, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
